uart_tx_wb_responder: RTL

Wishbone responder peripheral that holds the UART transmit register file and serialises one 8N1 frame per start command on tx_o. The control-unit master uses it as follows: it programs the baud increment, writes a TX byte, issues start, polls the busy/done status, then clears done. Bit timing uses a 32-bit phase accumulator whose increment is the programmed baud register.

---
 rtl/uart_tx_wb_responder.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_wb_responder.sv
// uart_tx_wb_responder: Wishbone register file plus an 8N1 UART transmitter.
// A phase accumulator paced by the BAUD register times each serial bit.
// Ports:
//   clk_i, rst_i               clock, synchronous active-high reset
//   addr_i, dat_i, we_i, sel_i Wishbone request (qualified by stb_i only)
//   cyc_i                      cycle qualifier, not used
//   stb_i                      strobe, one access per cycle
//   dat_o, ack_o, err_o        registered response, one cycle after stb_i
//   tx_o                       serial output, idle high
module uart_tx_wb_responder #(
    parameter logic [31:0] BAUD_INC_RESET = 32'h004B7F5B,
    parameter int unsigned DATA_BITS      = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    input  logic        we_i,
    input  logic [3:0]  sel_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    output logic        ack_o,
    output logic        err_o,
    output logic        tx_o
);

    localparam int unsigned     BIT_W       = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(DATA_BITS - 1);
    localparam logic [31:0]     ADDR_CTRL   = 32'h0000_0003;
    localparam logic [31:0]     ADDR_BAUD   = 32'h0000_0004;
    localparam logic [31:0]     ADDR_STATUS = 32'h0000_0005;
    localparam logic [31:0]     ADDR_TXDATA = 32'h0000_0007;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    state_e               state_q,   state_d;
    logic [31:0]          dat_q,     dat_d;
    logic                 ack_q,     ack_d;
    logic                 err_q,     err_d;
    logic                 tx_q,      tx_d;
    logic                 busy_q,    busy_d;
    logic                 done_q,    done_d;
    logic [31:0]          baud_q,    baud_d;
    logic [31:0]          acc_q,     acc_d;
    logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
    logic [BIT_W-1:0]     bit_q,     bit_d;

    logic tick;
    logic wr;
    logic start_cmd;
    logic unused_cyc;

    // Bus accesses are qualified by stb_i alone.
    assign unused_cyc = cyc_i;

    assign tick      = acc_q[31];
    assign wr        = stb_i & we_i;
    assign start_cmd = wr && (addr_i == ADDR_CTRL) && sel_i[0] && dat_i[7] && !busy_q;

    // Next-state: bus response, register writes, then the frame sequencer.
    always_comb begin
        state_d   = state_q;
        dat_d     = dat_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        tx_d      = tx_q;
        busy_d    = busy_q;
        done_d    = done_q;
        baud_d    = baud_q;
        acc_d     = acc_q;
        tx_data_d = tx_data_q;
        bit_d     = bit_q;

        if (stb_i) begin
            ack_d = 1'b1;
            case (addr_i)
                ADDR_CTRL:   dat_d = 32'h0;
                ADDR_BAUD:   dat_d = baud_q;
                ADDR_STATUS: dat_d = {26'b0, busy_q, done_q, 4'b0};
                ADDR_TXDATA: dat_d = 32'(tx_data_q);
                default: begin
                    dat_d = 32'h0;
                    err_d = 1'b1;
                end
            endcase
        end

        // Configuration is frozen for the duration of a frame.
        if (wr && !busy_q && (addr_i == ADDR_BAUD)) begin
            for (int i = 0; i < 4; i++) begin
                if (sel_i[i]) begin
                    baud_d[8*i +: 8] = dat_i[8*i +: 8];
                end
            end
        end
        if (wr && !busy_q && (addr_i == ADDR_TXDATA) && sel_i[0]) begin
            tx_data_d = dat_i[DATA_BITS-1:0];
        end
        if (wr && (addr_i == ADDR_STATUS)) begin
            done_d = 1'b0;
        end

        // Accumulator runs only while a frame is in flight; tick restarts it.
        if (state_q != IDLE) begin
            acc_d = tick ? 32'h0 : acc_q + baud_q;
        end

        // Assigned after the STATUS clear so that a completing frame wins.
        case (state_q)
            IDLE: begin
                if (start_cmd) begin
                    state_d = START;
                    busy_d  = 1'b1;
                    tx_d    = 1'b0;
                    acc_d   = 32'h0;
                    bit_d   = '0;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    bit_d   = '0;
                    tx_d    = tx_data_q[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_q == LAST_BIT) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                        tx_d  = tx_data_q[bit_d];
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    tx_d    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            dat_q     <= 32'h0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            baud_q    <= BAUD_INC_RESET;
            acc_q     <= 32'h0;
            tx_data_q <= '0;
            bit_q     <= '0;
        end else begin
            state_q   <= state_d;
            dat_q     <= dat_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            baud_q    <= baud_d;
            acc_q     <= acc_d;
            tx_data_q <= tx_data_d;
            bit_q     <= bit_d;
        end
    end

    assign dat_o = dat_q;
    assign ack_o = ack_q;
    assign err_o = err_q;
    assign tx_o  = tx_q;

endmodule
